// File: rtl/fpusb_pkg.sv
// ============================================================================
//  Module      : fpusb_pkg
//  Description : Shared constants and the pipeline stage tag for the shared
//                floating-point multiplier scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpusb_pkg;

  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 18;
  localparam int FP_W        = 1 + EXP_W + FRAC_W;
  localparam int MUL_LATENCY = 2;

  // Tag id is sized for the largest supported requester count.
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } stage_tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter; one-hot grant to the first
//                eligible index at or above rr_ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_rot_grant;

  // Rotate so rr_ptr lands on bit 0, take the lowest set bit, rotate back.
  assign w_rot       = NUM_REQ'({eligible, eligible} >> rr_ptr);
  assign w_rot_grant = w_rot & (~w_rot + NUM_REQ'(1));
  assign grant       = NUM_REQ'(({w_rot_grant, w_rot_grant} << rr_ptr) >> NUM_REQ);

endmodule

`default_nettype wire

// File: rtl/fp_mul_scheduler.sv
// ============================================================================
//  Module      : fp_mul_scheduler
//  Description : Shares one two-edge-latency FP multiplier among NUM_REQ
//                requesters with round-robin issue and per-requester results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_scheduler
  import fpusb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk_pll,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [NUM_REQ*FP_W-1:0] resp_data,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [FP_W-1:0]         mul_in_1,
  output logic [FP_W-1:0]         mul_in_2,
  input  logic [FP_W-1:0]         mul_out,
  output logic [CNT_W-1:0]        ops_issued
);

  localparam int C_PTR_W = $clog2(NUM_REQ);

  logic [C_PTR_W-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0] r_busy;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [FP_W-1:0]    r_resp_data [NUM_REQ];
  logic [FP_W-1:0]    r_mul_in_1;
  logic [FP_W-1:0]    r_mul_in_2;
  logic [CNT_W-1:0]   r_ops_issued;
  stage_tag_t         r_s1;
  stage_tag_t         r_s2;

  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_consume;
  logic               w_accept;
  logic [ID_W-1:0]    w_gid;
  logic [FP_W-1:0]    w_sel_a;
  logic [FP_W-1:0]    w_sel_b;
  logic [C_PTR_W-1:0] w_ptr_nxt;

  // Gating with rst_n keeps the grant quiet while reset is held.
  assign w_eligible = req_valid & ~r_busy & {NUM_REQ{rst_n}};
  assign w_consume  = r_resp_valid & resp_ready;
  assign w_accept   = |w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .eligible (w_eligible),
    .rr_ptr   (r_rr_ptr),
    .grant    (w_grant)
  );

  always_comb begin
    w_gid   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gid   = ID_W'(i);
        w_sel_a = req_a[i*FP_W +: FP_W];
        w_sel_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      if (w_gid == ID_W'(NUM_REQ-1)) w_ptr_nxt = '0;
      else                           w_ptr_nxt = C_PTR_W'(w_gid + ID_W'(1));
    end
  end

  always_ff @(posedge clk_pll) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_busy       <= '0;
      r_mul_in_1   <= '0;
      r_mul_in_2   <= '0;
      r_ops_issued <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_busy   <= (r_busy & ~w_consume) | w_grant;
      if (w_accept) begin
        r_mul_in_1   <= w_sel_a;
        r_mul_in_2   <= w_sel_b;
        r_ops_issued <= r_ops_issued + CNT_W'(1);
      end
      r_s1.valid <= w_accept;
      r_s1.id    <= w_gid;
      r_s2       <= r_s1;
    end
  end

  // Busy blocks re-issue, so a slot is never written and consumed together.
  always_ff @(posedge clk_pll) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_resp_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_s2.valid && r_s2.id == ID_W'(i)) begin
          r_resp_valid[i] <= 1'b1;
          r_resp_data[i]  <= mul_out;
        end else if (w_consume[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign resp_data[i*FP_W +: FP_W] = r_resp_data[i];
  end

  assign req_ready  = w_grant;
  assign resp_valid = r_resp_valid;
  assign mul_in_1   = r_mul_in_1;
  assign mul_in_2   = r_mul_in_2;
  assign ops_issued = r_ops_issued;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_scheduler.sv
// ============================================================================
//  Module      : tb_fp_mul_scheduler
//  Description : Self-checking bench for fp_mul_scheduler with a stand-in
//                two-edge multiplier model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_scheduler;
  import fpusb_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic                 clk_pll = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N*FP_W-1:0]    req_a;
  logic [N*FP_W-1:0]    req_b;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         resp_valid;
  logic [N*FP_W-1:0]    resp_data;
  logic [N-1:0]         resp_ready;
  logic [FP_W-1:0]      mul_in_1;
  logic [FP_W-1:0]      mul_in_2;
  logic [FP_W-1:0]      mul_out;
  logic [FP_W-1:0]      r_mul_pipe = '0;
  logic [CW-1:0]        ops_issued;

  logic [FP_W-1:0]      op_a [N];
  logic [FP_W-1:0]      op_b [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_pll = ~clk_pll;

  fp_mul_scheduler #(
    .NUM_REQ (N),
    .CNT_W   (CW)
  ) dut (
    .clk_pll    (clk_pll),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .mul_in_1   (mul_in_1),
    .mul_in_2   (mul_in_2),
    .mul_out    (mul_out),
    .ops_issued (ops_issued)
  );

  // Stand-in multiplier: any operand-dependent value exposes routing errors.
  function automatic logic [FP_W-1:0] fmul(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    return a + {b[13:0], b[26:14]};
  endfunction

  always @(posedge clk_pll) r_mul_pipe <= fmul(mul_in_1, mul_in_2);
  assign mul_out = r_mul_pipe;

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  rdy;
    logic [N-1:0]  exp_grant;
    logic [N-1:0]  exp_rv;
    logic [CW-1:0] exp_ops;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      req_valid  = vecs[r].valid;
      resp_ready = vecs[r].rdy;
      #1;
      chk($sformatf("row%0d req_ready", r), 64'(req_ready), 64'(vecs[r].exp_grant));
      tick();
      chk($sformatf("row%0d resp_valid", r), 64'(resp_valid), 64'(vecs[r].exp_rv));
      chk($sformatf("row%0d ops_issued", r), 64'(ops_issued), 64'(vecs[r].exp_ops));
      for (int i = 0; i < N; i++) begin
        if (vecs[r].exp_rv[i])
          chk($sformatf("row%0d resp_data%0d", r, i), 64'(resp_data[i*FP_W +: FP_W]),
              64'(fmul(op_a[i], op_b[i])));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int g0;
    int g2;
    int g3;

    op_a[0] = 27'h1FC0000;  op_b[0] = 27'h2000000;
    op_a[1] = 27'h2012345;  op_b[1] = 27'h41ABCDE;
    op_a[2] = 27'h5F00F00;  op_b[2] = 27'h1234567;
    op_a[3] = 27'h7FFFFFF;  op_b[3] = 27'h0000001;
    for (int i = 0; i < N; i++) begin
      req_a[i*FP_W +: FP_W] = op_a[i];
      req_b[i*FP_W +: FP_W] = op_b[i];
    end

    // All four requesting from reset, slots drained late.
    vecs[0]  = '{4'hF, 4'h0, 4'h1, 4'h0, 4'd1};
    vecs[1]  = '{4'hF, 4'h0, 4'h2, 4'h0, 4'd2};
    vecs[2]  = '{4'hF, 4'h0, 4'h4, 4'h1, 4'd3};
    vecs[3]  = '{4'hF, 4'h0, 4'h8, 4'h3, 4'd4};
    vecs[4]  = '{4'hF, 4'h0, 4'h0, 4'h7, 4'd4};
    vecs[5]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'd4};
    vecs[6]  = '{4'hF, 4'h1, 4'h0, 4'hE, 4'd4};
    vecs[7]  = '{4'hF, 4'h0, 4'h1, 4'hE, 4'd5};
    vecs[8]  = '{4'h0, 4'hE, 4'h0, 4'h0, 4'd5};
    vecs[9]  = '{4'h0, 4'h0, 4'h0, 4'h1, 4'd5};
    vecs[10] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'd5};
    // Fairness: requesters 0 and 2 always valid, consuming immediately.
    vecs[11] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'd1};
    vecs[12] = '{4'h5, 4'h5, 4'h4, 4'h0, 4'd2};
    vecs[13] = '{4'h5, 4'h5, 4'h0, 4'h1, 4'd2};
    vecs[14] = '{4'h5, 4'h5, 4'h0, 4'h4, 4'd2};
    vecs[15] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'd3};
    vecs[16] = '{4'h5, 4'h5, 4'h4, 4'h0, 4'd4};
    vecs[17] = '{4'h5, 4'h5, 4'h0, 4'h1, 4'd4};
    vecs[18] = '{4'h5, 4'h5, 4'h0, 4'h4, 4'd4};
    vecs[19] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'd5};
    vecs[20] = '{4'h5, 4'h5, 4'h4, 4'h0, 4'd6};

    // Reset state, with requests held to show the grant stays low.
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    resp_ready = '0;
    tick();
    tick();
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset resp_valid", 64'(resp_valid), 64'h0);
    chk("reset resp_data", 64'(resp_data != '0), 64'h0);
    chk("reset mul_in_1", 64'(mul_in_1), 64'h0);
    chk("reset mul_in_2", 64'(mul_in_2), 64'h0);
    chk("reset ops_issued", 64'(ops_issued), 64'h0);
    rst_n     = 1'b1;
    req_valid = '0;

    // Single request: 1.0 x 2.0 on requester 0.
    req_valid = 4'h1;
    #1;
    chk("single req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("single mul_in_1", 64'(mul_in_1), 64'(op_a[0]));
    chk("single mul_in_2", 64'(mul_in_2), 64'(op_b[0]));
    chk("single ops_issued", 64'(ops_issued), 64'h1);
    repeat (MUL_LATENCY - 1) begin
      tick();
      chk("single early resp_valid", 64'(resp_valid), 64'h0);
    end
    tick();
    chk("single resp_valid", 64'(resp_valid), 64'h1);
    chk("single resp_data", 64'(resp_data[FP_W-1:0]), 64'(fmul(op_a[0], op_b[0])));
    resp_ready = 4'h1;
    tick();
    chk("single consumed", 64'(resp_valid), 64'h0);
    chk("single data held", 64'(resp_data[FP_W-1:0]), 64'(fmul(op_a[0], op_b[0])));
    resp_ready = '0;

    do_reset();
    run_rows(0, 10);
    do_reset();
    run_rows(11, 20);

    // Backpressure on requester 1 for a dozen cycles.
    do_reset();
    g0 = 0; g2 = 0; g3 = 0;
    req_valid  = 4'hF;
    resp_ready = 4'hD;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (c >= 2) chk($sformatf("bp c%0d req_ready1", c), 64'(req_ready[1]), 64'h0);
      if (req_ready[0]) g0++;
      if (req_ready[2]) g2++;
      if (req_ready[3]) g3++;
      tick();
      if (c >= 3) begin
        chk($sformatf("bp c%0d resp_valid1", c), 64'(resp_valid[1]), 64'h1);
        chk($sformatf("bp c%0d resp_data1", c), 64'(resp_data[FP_W +: FP_W]),
            64'(fmul(op_a[1], op_b[1])));
      end
    end
    chk("bp grants r0", 64'(g0 >= 2), 64'h1);
    chk("bp grants r2", 64'(g2 >= 2), 64'h1);
    chk("bp grants r3", 64'(g3 >= 2), 64'h1);
    req_valid  = '0;
    resp_ready = 4'hF;
    tick();
    chk("bp release resp_valid1", 64'(resp_valid[1]), 64'h0);
    resp_ready = '0;

    // Reset one edge after an accept discards the in-flight op.
    do_reset();
    req_valid = 4'h1;
    #1;
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst ops_issued", 64'(ops_issued), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst c%0d resp_valid", c), 64'(resp_valid), 64'h0);
    end
    req_valid = 4'hF;
    #1;
    chk("midrst grant from ptr 0", 64'(req_ready), 64'h1);
    req_valid = '0;

    // Counter wrap: 17 accepts into a 4-bit counter.
    do_reset();
    resp_ready = 4'hF;
    acc = 0;
    for (int c = 0; c < 200 && acc < 17; c++) begin
      req_valid = 4'hF;
      #1;
      if (|(req_valid & req_ready)) acc++;
      tick();
    end
    req_valid = '0;
    chk("wrap accept count", 64'(acc), 64'd17);
    chk("wrap ops_issued", 64'(ops_issued), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
